// File: rtl/sn76489_audio_pkg.sv
// ---------------------------------------------------------------------------
// sn76489_audio_pkg
//
// Shared constants and helpers for the SN76489 audio output path.
//   SAMPLE_W  : width of a mixed PSG sample
//   SLOT_BITS : BCLK periods per I2S channel slot
//   SLOTS     : channel slots per I2S frame (left, right)
//   SILENCE   : offset-binary code for a silent sample
//   to_signed : offset-binary to two's complement (MSB flip)
// ---------------------------------------------------------------------------
package sn76489_audio_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int SLOT_BITS = 32;
    localparam int SLOTS     = 2;

    localparam logic [SAMPLE_W-1:0] SILENCE = 16'h8000;

    // Offset-binary and two's complement differ only in the sign bit.
    function automatic logic [SAMPLE_W-1:0] to_signed(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/sn76489_audio_decimator.sv
// ---------------------------------------------------------------------------
// sn76489_audio_decimator
//
// Reduces the per-clock PSG sample stream to one word per I2S frame.
// Build option (macro SN76489_I2S_AVG_EN):
//   defined   : boxcar average of every sample of the frame, truncated
//   undefined : sample-and-hold of the sample present in the wrap cycle
// A mute request seen in the wrap cycle replaces the word with silence.
//
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high
//   sample_in in   16-bit offset-binary sample, valid every clock
//   mute      in   force silence, only looked at when wrap is high
//   wrap      in   high in the last clock of each frame
//   word      out  frame word, offset-binary
// ---------------------------------------------------------------------------
module sn76489_audio_decimator
    import sn76489_audio_pkg::*;
`ifdef SN76489_I2S_AVG_EN
#(
    parameter int SHIFT = 7
)
`endif
(
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                mute,
    input  logic                wrap,
    output logic [SAMPLE_W-1:0] word
);

    logic [SAMPLE_W-1:0] word_q;
    logic [SAMPLE_W-1:0] word_d;

`ifdef SN76489_I2S_AVG_EN

    // Wide enough for 2^SHIFT full-scale samples, so the sum never overflows.
    localparam int ACC_W = SAMPLE_W + SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;

    // The wrap-cycle sample is part of the frame average, so the divide
    // uses the sum including it; the accumulator restarts empty either way.
    always_comb begin
        acc_sum = acc_q + ACC_W'(sample_in);
        acc_d   = acc_sum;
        word_d  = word_q;
        if (wrap) begin
            acc_d  = '0;
            word_d = mute ? SILENCE : acc_sum[SHIFT +: SAMPLE_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q  <= '0;
            word_q <= SILENCE;
        end else begin
            acc_q  <= acc_d;
            word_q <= word_d;
        end
    end

`else

    always_comb begin
        word_d = word_q;
        if (wrap) begin
            word_d = mute ? SILENCE : sample_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= SILENCE;
        end else begin
            word_q <= word_d;
        end
    end

`endif

    assign word = word_q;

endmodule

// File: rtl/sn76489_i2s_out.sv
// ---------------------------------------------------------------------------
// sn76489_i2s_out
//
// Converts the PSG mixer output to a mono Philips-format I2S stream. One
// word per frame is taken from sn76489_audio_decimator (build option
// SN76489_I2S_AVG_EN selects averaging vs. sample-and-hold), converted to
// two's complement and sent MSB first in both channel slots.
//
// Parameters:
//   BCLK_HALF_LOG2 : log2 of system clocks per BCLK half-period (0..3)
//
// Ports:
//   clock         in   PSG system clock
//   reset         in   synchronous, active-high
//   sample_in     in   16-bit offset-binary mixed sample, valid every clock
//   mute          in   force a silent word, sampled at frame wrap only
//   i2s_bclk      out  bit clock
//   i2s_lrclk     out  word select, 0 = left, 1 = right
//   i2s_sdata     out  serial data, MSB first
//   sample_strobe out  one-clock pulse when a new frame word is latched
// ---------------------------------------------------------------------------
module sn76489_i2s_out
    import sn76489_audio_pkg::*;
#(
    parameter int BCLK_HALF_LOG2 = 0
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                mute,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                sample_strobe
);

    localparam int K = BCLK_HALF_LOG2;
    localparam int W = 7 + K;

    // LRCLK rises one bit ahead of the right slot MSB and falls one bit
    // ahead of the next frame's left slot MSB.
    localparam logic [5:0] LR_FIRST    = 6'(SLOT_BITS - 1);
    localparam logic [5:0] LR_LAST_LOW = 6'(SLOT_BITS * SLOTS - 1);

    logic [W-1:0]        fc_q;
    logic [W-1:0]        fc_d;
    logic                bclk_q;
    logic                bclk_d;
    logic                lrclk_q;
    logic                lrclk_d;
    logic                sdata_q;
    logic                sdata_d;
    logic                strobe_q;
    logic                strobe_d;

    logic                wrap;
    logic [5:0]          bit_idx;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] tx;

    assign wrap    = (fc_q == '1);
    assign bit_idx = fc_q[W-1:K+1];
    assign tx      = to_signed(word);

    sn76489_audio_decimator
`ifdef SN76489_I2S_AVG_EN
        #(.SHIFT(W))
`endif
        u_decimator (
            .clock     (clock),
            .reset     (reset),
            .sample_in (sample_in),
            .mute      (mute),
            .wrap      (wrap),
            .word      (word)
        );

    // Bit index bit 4 clear means the first 16 bits of either slot, which
    // carry data; the remaining 16 bits of each slot are padded with zero.
    // Inverting the low four index bits gives 15-b, i.e. MSB first.
    always_comb begin
        fc_d     = fc_q + W'(1);
        bclk_d   = fc_q[K];
        lrclk_d  = (bit_idx >= LR_FIRST) && (bit_idx != LR_LAST_LOW);
        sdata_d  = 1'b0;
        if (!bit_idx[4]) begin
            sdata_d = tx[~bit_idx[3:0]];
        end
        strobe_d = wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fc_q     <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            fc_q     <= fc_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            strobe_q <= strobe_d;
        end
    end

    assign i2s_bclk      = bclk_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_sdata     = sdata_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_sn76489_i2s_out.sv
// ---------------------------------------------------------------------------
// tb_sn76489_i2s_out
//
// Drives two instances of sn76489_i2s_out (BCLK_HALF_LOG2 = 0 and 2) from
// the same stimulus and compares every output on every clock against a
// frame-level reference model. Table-driven frame vectors and a few
// hand-written sequences cover reset, mute, decimation, timing and
// mid-frame reset. Honours SN76489_I2S_AVG_EN for the expected words.
// ---------------------------------------------------------------------------
module tb_sn76489_i2s_out;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        mute;

    logic bclk0, lrclk0, sdata0, strobe0;
    logic bclk2, lrclk2, sdata2, strobe2;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = k0 instance, index 1 = k2 instance.
    int              mfc[2];
    logic [15:0]     mword[2];
    longint unsigned msum[2];
    logic [3:0]      mexp[2];
    int              last_fc[2];

    typedef struct {
        logic [15:0] sample;
        logic        mute;
        logic [15:0] exp_tx;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    sn76489_i2s_out #(.BCLK_HALF_LOG2(0)) dut_k0 (
        .clock         (clock),
        .reset         (reset),
        .sample_in     (sample_in),
        .mute          (mute),
        .i2s_bclk      (bclk0),
        .i2s_lrclk     (lrclk0),
        .i2s_sdata     (sdata0),
        .sample_strobe (strobe0)
    );

    sn76489_i2s_out #(.BCLK_HALF_LOG2(2)) dut_k2 (
        .clock         (clock),
        .reset         (reset),
        .sample_in     (sample_in),
        .mute          (mute),
        .i2s_bclk      (bclk2),
        .i2s_lrclk     (lrclk2),
        .i2s_sdata     (sdata2),
        .sample_strobe (strobe2)
    );

    function automatic int kOf(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Model: frame counter, per-bit slot rules and frame word bookkeeping.
    // Expected outputs describe the fc value of the clock just ended.
    task automatic modelUpdate(input int d);
        int          k;
        int          w;
        int          fc;
        int          b;
        int          p;
        logic [15:0] tx;
        logic        sd;
        logic        lr;
        logic        wr;
        k = kOf(d);
        w = 7 + k;
        if (reset) begin
            mfc[d]     = 0;
            mword[d]   = 16'h8000;
            msum[d]    = 0;
            mexp[d]    = 4'b0000;
            last_fc[d] = -1;
        end else begin
            fc = mfc[d];
            b  = fc >> (k + 1);
            p  = (fc >> k) & 1;
            tx = mword[d] ^ 16'h8000;
            if (b < 16)
                sd = tx[15 - b];
            else if (b >= 32 && b < 48)
                sd = tx[15 - (b - 32)];
            else
                sd = 1'b0;
            lr = (b >= 31 && b <= 62);
            wr = (fc == (1 << w) - 1);
            mexp[d] = {p[0], lr, sd, wr};
            msum[d] += sample_in;
            if (wr) begin
`ifdef SN76489_I2S_AVG_EN
                mword[d] = 16'(msum[d] >> w);
`else
                mword[d] = sample_in;
`endif
                if (mute)
                    mword[d] = 16'h8000;
                msum[d] = 0;
            end
            last_fc[d] = fc;
            mfc[d]     = (fc + 1) % (1 << w);
        end
    endtask

    task automatic checkOutput();
        check($sformatf("k0 outputs fc=%0d", last_fc[0]), {28'd0, bclk0, lrclk0, sdata0, strobe0}, {28'd0, mexp[0]});
        check($sformatf("k2 outputs fc=%0d", last_fc[1]), {28'd0, bclk2, lrclk2, sdata2, strobe2}, {28'd0, mexp[1]});
    endtask

    task automatic step();
        @(posedge clock);
        modelUpdate(0);
        modelUpdate(1);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic m);
        sample_in = s;
        mute      = m;
        step();
    endtask

    // Step until the next clock presents fc=0 to instance d.
    task automatic alignFrame(input int d);
        int n;
        n = 0;
        while (mfc[d] != 0 && n < 1000) begin
            step();
            n++;
        end
        check("align frame within bound", {31'd0, n < 1000}, 32'd1);
    endtask

    // Runs one full frame of instance d, collecting both slots from sdata.
    // Halfway through, sample_in is replaced by mid_sample.
    task automatic captureFrame(input int d, input logic [15:0] mid_sample,
                                output logic [15:0] left, output logic [15:0] right,
                                output int strobe_at);
        int k;
        int len;
        int b;
        logic sd;
        logic st;
        k         = kOf(d);
        len       = 1 << (7 + k);
        left      = 16'h0000;
        right     = 16'h0000;
        strobe_at = 0;
        for (int i = 1; i <= len; i++) begin
            if (i == len / 2)
                sample_in = mid_sample;
            step();
            sd = (d == 0) ? sdata0 : sdata2;
            st = (d == 0) ? strobe0 : strobe2;
            if (st && strobe_at == 0)
                strobe_at = i;
            if (((last_fc[d] >> k) & 1) == 0) begin
                b = last_fc[d] >> (k + 1);
                if (b < 16)
                    left[15 - b] = sd;
                else if (b >= 32 && b < 48)
                    right[15 - (b - 32)] = sd;
            end
        end
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] r;
        int          st_at;
        int          n;
        logic        prev;
        logic [15:0] exp_alt;

        vecs[0] = '{16'hC000, 1'b0, 16'h4000};
        vecs[1] = '{16'hFFFF, 1'b1, 16'h0000};
        vecs[2] = '{16'hFFFF, 1'b0, 16'h7FFF};
        vecs[3] = '{16'h0000, 1'b0, 16'h8000};
        vecs[4] = '{16'h1234, 1'b0, 16'h9234};
        vecs[5] = '{16'h8000, 1'b0, 16'h0000};

        // Reset held 5 clocks: outputs all zero throughout.
        reset     = 1'b1;
        sample_in = 16'h8000;
        mute      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("outputs during reset", {24'd0, bclk0, lrclk0, sdata0, strobe0, bclk2, lrclk2, sdata2, strobe2}, 32'd0);
        end

        // Frame 0 after release carries silence; first strobe 128 clocks in.
        reset = 1'b0;
        captureFrame(0, 16'h8000, l, r, st_at);
        check("frame0 left", {16'd0, l}, 32'h0000);
        check("frame0 right", {16'd0, r}, 32'h0000);
        check("first strobe delay", st_at, 128);

        // Table: one frame of constant input, next frame must carry exp_tx.
        foreach (vecs[i]) begin
            alignFrame(0);
            for (int j = 0; j < 128; j++)
                applyStimulus(vecs[i].sample, vecs[i].mute);
            captureFrame(0, vecs[i].sample, l, r, st_at);
            check($sformatf("vec%0d left", i), {16'd0, l}, {16'd0, vecs[i].exp_tx});
            check($sformatf("vec%0d right", i), {16'd0, r}, {16'd0, vecs[i].exp_tx});
        end

        // Alternating 0x0000/0x1000, 0x1000 in the wrap cycle.
`ifdef SN76489_I2S_AVG_EN
        exp_alt = 16'h8800;
`else
        exp_alt = 16'h9000;
`endif
        alignFrame(0);
        for (int j = 0; j < 128; j++)
            applyStimulus((j % 2 == 1) ? 16'h1000 : 16'h0000, 1'b0);
        captureFrame(0, 16'h1000, l, r, st_at);
        check("alternating left", {16'd0, l}, {16'd0, exp_alt});
        check("alternating right", {16'd0, r}, {16'd0, exp_alt});

        // k=2: BCLK period 8 clocks, frame 512 clocks.
        n    = 0;
        prev = bclk2;
        step();
        while (!(!prev && bclk2) && n < 50) begin
            prev = bclk2;
            step();
            n++;
        end
        n    = 1;
        prev = bclk2;
        step();
        while (!(!prev && bclk2) && n < 50) begin
            prev = bclk2;
            step();
            n++;
        end
        check("k2 bclk period", n, 8);

        n = 0;
        while (!strobe2 && n < 1100) begin
            step();
            n++;
        end
        n = 1;
        step();
        while (!strobe2 && n < 1100) begin
            step();
            n++;
        end
        check("k2 strobe period", n, 512);

        // k=2: sample_in changes mid-frame, frame in flight unchanged.
        alignFrame(1);
        for (int j = 0; j < 512; j++)
            applyStimulus(16'h3000, 1'b0);
        captureFrame(1, 16'h7777, l, r, st_at);
        check("k2 midframe left", {16'd0, l}, 32'hB000);
        check("k2 midframe right", {16'd0, r}, 32'hB000);

        // Reset at b=20 with the accumulator loaded, then restart clean.
        alignFrame(0);
        for (int j = 0; j < 40; j++)
            applyStimulus(16'hFFFF, 1'b0);
        reset = 1'b1;
        step();
        check("outputs after midframe reset", {24'd0, bclk0, lrclk0, sdata0, strobe0, bclk2, lrclk2, sdata2, strobe2}, 32'd0);
        reset     = 1'b0;
        sample_in = 16'h2000;
        captureFrame(0, 16'h2000, l, r, st_at);
        check("post-reset frame0 left", {16'd0, l}, 32'h0000);
        check("post-reset strobe delay", st_at, 128);
        captureFrame(0, 16'h2000, l, r, st_at);
        check("post-reset frame1 left", {16'd0, l}, 32'hA000);
        check("post-reset frame1 right", {16'd0, r}, 32'hA000);

        // Random samples with occasional mute, checked every clock.
        for (int j = 0; j < 3000; j++)
            applyStimulus(16'($urandom), ($urandom_range(0, 7) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
